// File: rtl/pc_fetch_ctrl.sv
// IF-stage sequencer: drives the PC register controls and a single-outstanding
// SRAM-like fetch bus, with delayed-branch, exception redirect and stall buffering.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_en,
    output logic [31:0] pc_next,
    output logic        pc_flush,
    output logic [31:0] pc_new,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        stall_in,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t      state_q;
    logic        br_pend_q;
    logic [31:0] br_tgt_q;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_pc_q;

    logic active;
    logic exc;
    logic deliver;

    assign active = (state_q != IDLE);
    assign exc    = exc_valid && active;

    // An exception in the same cycle wins over any delivery.
    assign deliver = !exc &&
                     (((state_q == WAIT) && inst_data_ok && !stall_in) ||
                      ((state_q == HOLD) && !stall_in));

    always_comb begin
        inst_req  = (state_q == REQ);
        inst_addr = (state_q == REQ) ? pc_cur : 32'd0;
        pc_flush  = exc;
        pc_new    = exc ? exc_pc : 32'd0;
        pc_en     = deliver;
        pc_next   = 32'd0;
        if (active) begin
            pc_next = br_pend_q ? br_tgt_q : (pc_cur + 32'd4);
        end
        if_valid  = deliver;
        if_inst   = 32'd0;
        if_pc     = 32'd0;
        if (deliver) begin
            if_inst = (state_q == HOLD) ? buf_inst_q : inst_rdata;
            if_pc   = (state_q == HOLD) ? buf_pc_q   : pc_cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= 32'd0;
            buf_inst_q <= 32'd0;
            buf_pc_q   <= 32'd0;
        end else if (exc) begin
            br_pend_q  <= 1'b0;
            br_tgt_q   <= 32'd0;
            buf_inst_q <= 32'd0;
            buf_pc_q   <= 32'd0;
            case (state_q)
                REQ:     state_q <= inst_addr_ok ? DISCARD : REQ;
                WAIT:    state_q <= inst_data_ok ? REQ : DISCARD;
                HOLD:    state_q <= REQ;
                DISCARD: state_q <= inst_data_ok ? REQ : DISCARD;
                default: state_q <= REQ;
            endcase
        end else begin
            // Clear on delivery only if pending before this cycle; a branch arriving
            // now (with nothing pending) applies after the next delivered instruction.
            if (deliver && br_pend_q) begin
                br_pend_q <= 1'b0;
            end
            if (active && branch_valid && !br_pend_q) begin
                br_pend_q <= 1'b1;
                br_tgt_q  <= branch_target;
            end
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (inst_addr_ok) state_q <= WAIT;
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (stall_in) begin
                            buf_inst_q <= inst_rdata;
                            buf_pc_q   <= pc_cur;
                            state_q    <= HOLD;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_in) state_q <= REQ;
                end
                DISCARD: begin
                    if (inst_data_ok) state_q <= REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_reset_pc: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE) |=> (pc_cur == RESET_PC));

    a_en_flush: assert property (@(posedge clk) disable iff (rst)
        !(pc_en && pc_flush));

endmodule
